// File: rtl/cd_column_normalize_if.sv
// Handshake and data bundle for the column-normalise block: launch request and
// input vector in one direction, unit vector, norm and completion pulse back.
interface cd_column_normalize_if #(
   parameter int WIDTH = 16
);
   logic                    start;
   logic signed [WIDTH-1:0] h1;
   logic signed [WIDTH-1:0] h2;
   logic signed [WIDTH-1:0] h3;
   logic signed [WIDTH-1:0] h4;
   logic signed [WIDTH-1:0] q1;
   logic signed [WIDTH-1:0] q2;
   logic signed [WIDTH-1:0] q3;
   logic signed [WIDTH-1:0] q4;
   logic signed [WIDTH-1:0] norm;
   logic                    finish;

   modport master (
      output start, h1, h2, h3, h4,
      input  q1, q2, q3, q4, norm, finish
   );

   modport slave (
      input  start, h1, h2, h3, h4,
      output q1, q2, q3, q4, norm, finish
   );
endinterface

// File: rtl/cd_column_normalize.sv
// Normalises a four-element signed fixed-point column vector: sum of squares,
// bit-serial square root, then four parallel bit-serial divisions by the norm.
module cd_column_normalize #(
   parameter int WIDTH = 16,
   parameter int FBITS = 8
) (
   input logic                   clk,
   input logic                   reset,
   cd_column_normalize_if.slave  bus
);

   localparam int SW = 2*WIDTH + 2;
   localparam int RW = WIDTH + 4;
   localparam int DW = WIDTH + FBITS;
   localparam int CW = $clog2(DW + 1);

   localparam logic [CW-1:0]          SQRT_LAST = CW'(WIDTH);
   localparam logic [CW-1:0]          DIV_LAST  = CW'(DW - 1);
   localparam logic [WIDTH:0]         ROOT_LIM  = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic [DW-1:0]          POS_LIM   = {{(FBITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [DW-1:0]          NEG_LIM   = {{FBITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] QMAX     = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] QMIN     = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD, SUMSQ, SQRT, DIV, DONE} state_t;

   state_t                  state_q;
   logic                    startLow_q;
   logic [CW-1:0]           cnt_q;
   logic signed [WIDTH-1:0] h_q        [4];
   logic [SW-1:0]           sumRad_q;
   logic [WIDTH+1:0]        sqRem_q;
   logic [WIDTH:0]          root_q;
   logic [WIDTH-1:0]        divisor_q;
   logic [DW-1:0]           dividend_q [4];
   logic [WIDTH-1:0]        dRem_q     [4];
   logic [DW-1:0]           quot_q     [4];
   logic signed [WIDTH-1:0] q_q        [4];
   logic signed [WIDTH-1:0] norm_q;
   logic                    finish_q;

   logic signed [WIDTH-1:0] hIn     [4];
   logic [WIDTH-1:0]        hMag    [4];
   logic [SW-1:0]           sumSq_d;
   logic [RW-1:0]           sqCand;
   logic [RW-1:0]           sqTrial;
   logic                    sqFits;
   logic [WIDTH+1:0]        sqRem_d;
   logic [WIDTH:0]          root_d;
   logic [WIDTH-1:0]        rootSat;
   logic [WIDTH:0]          dCand   [4];
   logic                    dFits   [4];
   logic [WIDTH-1:0]        dRem_d  [4];
   logic signed [WIDTH-1:0] qFinal  [4];

   assign hIn[0] = bus.h1;
   assign hIn[1] = bus.h2;
   assign hIn[2] = bus.h3;
   assign hIn[3] = bus.h4;

   assign bus.q1     = q_q[0];
   assign bus.q2     = q_q[1];
   assign bus.q3     = q_q[2];
   assign bus.q4     = q_q[3];
   assign bus.norm   = norm_q;
   assign bus.finish = finish_q;

   // Magnitudes, exact sum of squares, one root step and one step of each divider.
   always_comb begin
      sumSq_d = '0;
      for (int i = 0; i < 4; i++) begin
         hMag[i] = h_q[i][WIDTH-1] ? $unsigned(-h_q[i]) : $unsigned(h_q[i]);
         sumSq_d = sumSq_d + SW'(hMag[i]) * SW'(hMag[i]);
      end

      sqCand  = {sqRem_q, sumRad_q[SW-1 -: 2]};
      sqTrial = RW'({root_q, 2'b01});
      sqFits  = (sqCand >= sqTrial);
      sqRem_d = (WIDTH+2)'(sqFits ? (sqCand - sqTrial) : sqCand);
      root_d  = {root_q[WIDTH-1:0], sqFits};
      rootSat = (root_d > ROOT_LIM) ? ROOT_LIM[WIDTH-1:0] : root_d[WIDTH-1:0];

      for (int i = 0; i < 4; i++) begin
         dCand[i]  = {dRem_q[i], dividend_q[i][DW-1]};
         dFits[i]  = (dCand[i] >= {1'b0, divisor_q});
         dRem_d[i] = WIDTH'(dFits[i] ? (dCand[i] - {1'b0, divisor_q}) : dCand[i]);
      end

      // Reapply the sign and clamp the truncated quotient magnitude.
      for (int i = 0; i < 4; i++) begin
         if (divisor_q == '0) begin
            qFinal[i] = '0;
         end else if (h_q[i][WIDTH-1]) begin
            qFinal[i] = (quot_q[i] > NEG_LIM) ? QMIN : $signed(WIDTH'(DW'(0) - quot_q[i]));
         end else begin
            qFinal[i] = (quot_q[i] > POS_LIM) ? QMAX : $signed(quot_q[i][WIDTH-1:0]);
         end
      end
   end

   // Control sequence and datapath registers; startLow_q arms the launch only
   // after start has been seen low, so a level held through reset cannot launch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         startLow_q <= 1'b0;
         cnt_q      <= '0;
         sumRad_q   <= '0;
         sqRem_q    <= '0;
         root_q     <= '0;
         divisor_q  <= '0;
         norm_q     <= '0;
         finish_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            h_q[i]        <= '0;
            dividend_q[i] <= '0;
            dRem_q[i]     <= '0;
            quot_q[i]     <= '0;
            q_q[i]        <= '0;
         end
      end else begin
         startLow_q <= ~bus.start;
         finish_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && startLow_q) state_q <= LOAD;
            end
            LOAD: begin
               for (int i = 0; i < 4; i++) h_q[i] <= hIn[i];
               state_q <= SUMSQ;
            end
            SUMSQ: begin
               sumRad_q <= sumSq_d;
               sqRem_q  <= '0;
               root_q   <= '0;
               cnt_q    <= '0;
               for (int i = 0; i < 4; i++) begin
                  dividend_q[i] <= {hMag[i], {FBITS{1'b0}}};
                  dRem_q[i]     <= '0;
                  quot_q[i]     <= '0;
               end
               state_q <= SQRT;
            end
            SQRT: begin
               sumRad_q <= {sumRad_q[SW-3:0], 2'b00};
               sqRem_q  <= sqRem_d;
               root_q   <= root_d;
               if (cnt_q == SQRT_LAST) begin
                  divisor_q <= rootSat;
                  cnt_q     <= '0;
                  state_q   <= DIV;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DIV: begin
               for (int i = 0; i < 4; i++) begin
                  dividend_q[i] <= {dividend_q[i][DW-2:0], 1'b0};
                  dRem_q[i]     <= dRem_d[i];
                  quot_q[i]     <= {quot_q[i][DW-2:0], dFits[i]};
               end
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               norm_q   <= $signed(divisor_q);
               for (int i = 0; i < 4; i++) q_q[i] <= qFinal[i];
               finish_q <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cd_column_normalize.sv
// Self-checking bench for cd_column_normalize: directed table, random vectors
// against an arithmetic reference, and start/reset corner sequences.
module tb_cd_column_normalize;

   localparam int W = 16;
   localparam int F = 8;
   localparam int LAT = 45;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cd_column_normalize_if #(.WIDTH(W)) bus ();

   cd_column_normalize #(.WIDTH(W), .FBITS(F)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int h1, h2, h3, h4;
      int mode;
      int expNorm;
      int e1, e2, e3, e4;
   } vec_t;

   int nChecks = 0;
   int nFails  = 0;
   int lastNorm = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: floor square root of the exact sum of squares, clamped norm,
   // then a truncating signed division of h scaled by 2^F.
   function automatic int refNorm(input int a, input int b, input int c, input int d);
      longint s, lo, hi, mid;
      s  = longint'(a)*a + longint'(b)*b + longint'(c)*c + longint'(d)*d;
      lo = 0;
      hi = longint'(1) << 18;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid*mid <= s) lo = mid;
         else hi = mid - 1;
      end
      if (lo > 32767) lo = 32767;
      return int'(lo);
   endfunction

   function automatic int refQ(input int h, input int n);
      longint v;
      if (n == 0) return 0;
      v = (longint'(h) * (longint'(1) << F)) / n;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return int'(v);
   endfunction

   // mode 0: pulse start; 1: hold start high afterwards; 2: toggle start while busy.
   task automatic applyStimulus(input vec_t v, output int cycles, output bit got);
      @(negedge clk);
      bus.h1 = 16'(v.h1);
      bus.h2 = 16'(v.h2);
      bus.h3 = 16'(v.h3);
      bus.h4 = 16'(v.h4);
      bus.start = 1'b1;
      cycles = 0;
      got = 1'b0;
      while (!got && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1 && v.mode != 1) bus.start = 1'b0;
         if (v.mode == 2 && cycles >= 3 && cycles <= 40) bus.start = (cycles % 3 == 0);
         if (v.mode == 2 && cycles == 41) bus.start = 1'b0;
         if (cycles == 2) begin
            bus.h1 = 16'($urandom);
            bus.h2 = 16'($urandom);
            bus.h3 = 16'($urandom);
            bus.h4 = 16'($urandom);
         end
         if (cycles == 30) checkOutput("hold_norm", int'(bus.norm), lastNorm);
         if (bus.finish) got = 1'b1;
      end
   endtask

   task automatic runVector(input vec_t v, input string tag);
      int cycles;
      bit got;
      applyStimulus(v, cycles, got);
      checkOutput({tag, "_finish_seen"}, int'(got), 1);
      checkOutput({tag, "_latency"}, cycles, LAT);
      checkOutput({tag, "_norm"}, int'(bus.norm), v.expNorm);
      checkOutput({tag, "_q1"}, int'(bus.q1), v.e1);
      checkOutput({tag, "_q2"}, int'(bus.q2), v.e2);
      checkOutput({tag, "_q3"}, int'(bus.q3), v.e3);
      checkOutput({tag, "_q4"}, int'(bus.q4), v.e4);
      @(negedge clk);
      checkOutput({tag, "_finish_one_cycle"}, int'(bus.finish), 0);
      checkOutput({tag, "_norm_held"}, int'(bus.norm), v.expNorm);
      lastNorm = v.expNorm;
   endtask

   task automatic countFinish(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.finish) pulses++;
      end
   endtask

   vec_t vecs[8];

   initial begin
      int pulses;
      int a, b, c, d, n;
      vec_t rv;

      vecs[0] = '{256, 0, 0, 0, 0, 256, 256, 0, 0, 0};
      vecs[1] = '{768, 1024, 0, 0, 0, 1280, 153, 204, 0, 0};
      vecs[2] = '{-768, 0, 1024, 0, 2, 1280, -153, 0, 204, 0};
      vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{32767, 32767, 32767, 32767, 0, 32767, 256, 256, 256, 256};
      vecs[5] = '{-32768, 0, 0, 0, 0, 32767, -256, 0, 0, 0};
      vecs[6] = '{1, 1, 0, 0, 0, 1, 256, 256, 0, 0};
      vecs[7] = '{256, 256, 256, 256, 1, 512, 128, 128, 128, 128};

      // Reset with start held high: release must not count as a rising edge.
      reset = 1'b0;
      bus.start = 1'b1;
      bus.h1 = 16'd256; bus.h2 = 16'd0; bus.h3 = 16'd0; bus.h4 = 16'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_norm", int'(bus.norm), 0);
      checkOutput("reset_q1", int'(bus.q1), 0);
      checkOutput("reset_finish", int'(bus.finish), 0);
      reset = 1'b1;
      countFinish(60, pulses);
      checkOutput("no_launch_on_release", pulses, 0);
      bus.start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

      // Start still high from the last table entry: no relaunch.
      countFinish(60, pulses);
      checkOutput("held_start_no_relaunch", pulses, 0);
      checkOutput("idle_hold_q1", int'(bus.q1), 128);
      bus.start = 1'b0;
      @(negedge clk);

      // Abort mid-computation with reset.
      @(negedge clk);
      bus.h1 = 16'd768; bus.h2 = 16'd1024;
      bus.start = 1'b1;
      repeat (10) @(negedge clk);
      bus.start = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("abort_norm", int'(bus.norm), 0);
      checkOutput("abort_q1", int'(bus.q1), 0);
      checkOutput("abort_finish", int'(bus.finish), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      lastNorm = 0;
      countFinish(60, pulses);
      checkOutput("abort_no_finish", pulses, 0);
      runVector(vecs[1], "after_abort");

      // Random vectors against the reference model.
      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) begin
            a = $urandom_range(1023) - 512; b = $urandom_range(1023) - 512;
            c = $urandom_range(1023) - 512; d = $urandom_range(1023) - 512;
         end else begin
            a = $urandom_range(65535) - 32768; b = $urandom_range(65535) - 32768;
            c = $urandom_range(65535) - 32768; d = $urandom_range(65535) - 32768;
         end
         n  = refNorm(a, b, c, d);
         rv = '{a, b, c, d, (k % 5 == 0) ? 2 : 0, n,
                refQ(a, n), refQ(b, n), refQ(c, n), refQ(d, n)};
         runVector(rv, $sformatf("rand%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/cd_column_normalize.md
CD_COLUMN_NORMALIZE -- requirements
Module: cd_column_normalize

Interface
REQ-001 Parameter WIDTH, default 16, total bits of every signed fixed-point data port.
REQ-002 Parameter FBITS, default 8, fractional bits (two's-complement Q(WIDTH-FBITS).FBITS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to normalise the vector on h1..h4.
REQ-006 h1, h2, h3, h4  input  WIDTH signed  column vector elements.
REQ-007 q1, q2, q3, q4  output  WIDTH signed registered  unit-vector elements h_i/norm.
REQ-008 norm  output  WIDTH signed registered  Euclidean norm sqrt(h1²+h2²+h3²+h4²).
REQ-009 finish  output  1 registered  one-cycle completion pulse.

Function
REQ-010 FSM states: IDLE, LOAD, SUMSQ, SQRT, DIV, DONE.
REQ-011 Launch only in IDLE on a start rising edge (start=1 and start=0 on the previous clock); a start held high after completion does not relaunch.
REQ-012 LOAD: register h1..h4; inputs are ignored after LOAD until the next launch.
REQ-013 SUMSQ: S = sum of four exact WIDTH×WIDTH signed squares, unsigned 2*WIDTH+2 bits, 2*FBITS fractional bits; no truncation.
REQ-014 SQRT: restoring bit-serial integer square root of S, one result bit per cycle, WIDTH+1 cycles; result floor(sqrt(S)) has FBITS fractional bits.
REQ-015 norm saturates to 2^(WIDTH-1)-1 when the root exceeds it; the saturated value is used for division.
REQ-016 DIV: four parallel restoring divisions of |h_i|<<FBITS by norm, one quotient bit per cycle, WIDTH+FBITS cycles; quotient truncated toward zero, sign of h_i reapplied.
REQ-017 q_i saturates to +(2^(WIDTH-1)-1) or -(2^(WIDTH-1)) on overflow.
REQ-018 norm=0: all q_i=0, norm=0, no division error; same latency.
REQ-019 DONE: q1..q4 and norm update together, finish=1 for exactly one cycle, then IDLE.
REQ-020 Latency fixed: finish high at clock edge 3+(WIDTH+1)+(WIDTH+FBITS) after the launch edge (44 for defaults), independent of data.
REQ-021 start toggling while busy is ignored; outputs hold previous results until DONE.
REQ-022 Outputs hold last results indefinitely in IDLE.

Reset
REQ-023 reset low asynchronously forces IDLE; q1..q4, norm, finish, all internal registers and the start-edge history to 0.
REQ-024 reset mid-computation aborts it; no finish pulse; a fresh start rising edge after release is required.
REQ-025 start high during reset release is not a rising edge until it has been seen low.

Verification
REQ-026 h=(256,0,0,0) -> norm=256, q=(256,0,0,0), finish one cycle, 44 cycles after launch.
REQ-027 h=(768,1024,0,0) (3.0,4.0) -> norm=1280, q1=153, q2=204, q3=q4=0.
REQ-028 h=(-768,0,1024,0) -> norm=1280, q1=-153, q3=204, others 0.
REQ-029 h=(256,256,256,256) -> norm=512, all q=128; start held high afterwards yields no second finish.
REQ-030 h=all 0 -> norm=0, all q=0; h=all 0x7FFF -> norm=0x7FFF, all q=256.
REQ-031 reset low 10 cycles after launch -> outputs 0, no finish; new launch completes normally.
